// File: rtl/zero_cmp_pkg.sv
// Shared definitions for the bit-serial zero comparator.
//   state_t          : two-state scan FSM (IDLE, SHIFT)
//   ZC_WIDTH_DEFAULT : default operand width (32)
//   cnt_width()      : bit-counter width, $clog2(WIDTH+1), so the counter can hold WIDTH
package zero_cmp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned ZC_WIDTH_DEFAULT = 32;
  localparam int unsigned ZC_CNT_W_DEFAULT = $clog2(ZC_WIDTH_DEFAULT + 1);

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/zero_cmp_serial_if.sv
// Request/result bundle for zero_cmp_serial.
//   start  : request a compare (sampled only while idle)
//   number : signed two's-complement operand, sampled with start
//   busy   : scan in progress
//   done   : one-cycle pulse when lt/eq/gt are updated
//   lt/eq/gt : operand <0, ==0, >0 (held until the next done)
// master drives the request, slave (the comparator) drives the results.
interface zero_cmp_serial_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] number;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
    output start, number,
    input  busy, done, lt, eq, gt
  );

  modport slave (
    input  start, number,
    output busy, done, lt, eq, gt
  );
endinterface

// File: rtl/zero_cmp_shifter.sv
// Loadable MSB-first shift register plus down-counter for the serial scan.
//   clk_i, rst_ni : clock, async active-low reset (clears register and counter)
//   load_i        : load data_i and set the counter to WIDTH
//   shift_i       : shift left by one and decrement the counter
//   data_i        : operand to load
//   msb_o         : bit consumed on the current edge
//   first_o       : current bit is the first of the word (the sign)
//   last_o        : current bit is the last of the word
module zero_cmp_shifter
  import zero_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = ZC_WIDTH_DEFAULT,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o,
  output logic             first_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = data_i;
      cnt_d = CNT_LOAD;
    end else if (shift_i) begin
      sr_d  = {sr_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb_o   = sr_q[WIDTH-1];
  assign first_o = (cnt_q == CNT_LOAD);
  assign last_o  = (cnt_q == CNT_ONE);

endmodule

// File: rtl/zero_cmp_serial.sv
// Bit-serial signed zero comparator: accepts a word on start, scans it one
// bit per clock MSB-first and reports lt/eq/gt with a one-cycle done pulse.
//   clk     : rising-edge clock
//   reset_n : async active-low reset; aborts any scan without a result
//   bus     : zero_cmp_serial_if.slave (start/number in, busy/done/lt/eq/gt out)
// Optional macro ZERO_CMP_SERIAL_EARLY_EXIT_EN: finish as soon as the first 1
// is consumed (sign 1 -> lt at E1, later 1 -> gt); zero still takes WIDTH cycles.
module zero_cmp_serial
  import zero_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = ZC_WIDTH_DEFAULT
) (
  input logic               clk,
  input logic               reset_n,
  zero_cmp_serial_if.slave  bus
);

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic   sign_q, sign_d;
  logic   any_one_q, any_one_d;

  logic   load, shift, msb, first, last;
  logic   neg, one, finish;

  zero_cmp_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (bus.number),
    .msb_o   (msb),
    .first_o (first),
    .last_o  (last)
  );

  // Classification including the bit consumed on this edge, so the result
  // can be registered on the same edge that consumes the deciding bit.
  assign neg = first ? msb : sign_q;
  assign one = any_one_q | (msb & ~first);

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    lt_d      = lt_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    sign_d    = sign_q;
    any_one_d = any_one_q;
    load      = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          sign_d    = 1'b0;
          any_one_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (first) sign_d = msb;
        else if (msb) any_one_d = 1'b1;
`ifdef ZERO_CMP_SERIAL_EARLY_EXIT_EN
        finish = last | msb;
`else
        finish = last;
`endif
        if (finish) begin
          done_d  = 1'b1;
          lt_d    = neg;
          eq_d    = ~neg & ~one;
          gt_d    = ~neg & one;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      sign_q    <= 1'b0;
      any_one_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      sign_q    <= sign_d;
      any_one_q <= any_one_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.lt   = lt_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;

endmodule
